// File: rtl/instr_fetch.sv
// instr_fetch: IF stage with IF/ID register, one-outstanding imem handshake, stall skid buffer and redirect drain
// ports: clk, rst_n (sync, active-low) | imem_req/imem_addr out, imem_rdata/imem_ready in |
//        stall, redirect, redirect_pc in | instr, opcode, pc_plus4, instr_valid out (IF/ID)
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc, r_fetch_addr, r_pc_plus4;
  logic [31:0]       r_instr, r_skid;
  logic              r_valid, r_gap;
  logic              w_ack, w_pend;
  logic [ADDR_W-1:0] w_next;
  // r_gap forces one idle cycle after each completed request
  assign imem_req    = rst_n && r_state != HOLD && !r_gap;
  assign w_ack       = imem_req && imem_ready;
  assign w_pend      = imem_req && !imem_ready;
  assign w_next      = r_fetch_addr + ADDR_W'(4);
  assign imem_addr   = r_fetch_addr;
  assign instr       = r_valid ? r_instr : 32'h0;
  assign opcode      = instr[31:26];
  assign pc_plus4    = r_pc_plus4;
  assign instr_valid = r_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_pc_plus4   <= '0;
      r_instr      <= '0;
      r_skid       <= '0;
      r_valid      <= 1'b0;
      r_gap        <= 1'b0;
    end else begin
      r_gap <= w_ack;
      if (redirect) begin
        r_valid <= 1'b0;
        r_skid  <= '0;
        r_pc    <= redirect_pc;
        // a request still in flight must be drained before the new target is fetched
        r_state <= w_pend ? DRAIN : FETCH;
        if (!w_pend) r_fetch_addr <= redirect_pc;
      end else begin
        case (r_state)
          FETCH: begin
            if (w_ack && (!r_valid || !stall)) begin
              r_instr      <= imem_rdata;
              r_pc_plus4   <= w_next;
              r_valid      <= 1'b1;
              r_pc         <= w_next;
              r_fetch_addr <= w_next;
            end else if (w_ack) begin
              r_skid  <= imem_rdata;
              r_state <= HOLD;
            end else if (!stall) begin
              r_valid <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              r_instr      <= r_skid;
              r_pc_plus4   <= w_next;
              r_valid      <= 1'b1;
              r_pc         <= w_next;
              r_fetch_addr <= w_next;
              r_state      <= FETCH;
            end
          end
          DRAIN: begin
            if (w_ack) begin
              r_fetch_addr <= r_pc;
              r_state      <= FETCH;
            end
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end
endmodule
